// File: rtl/cv32e40px_rf_wb_pkg.sv
// Shared types and constants for the register-file write-back buffer.
// RF_WB_ADDR_W/RF_WB_DATA_W fix the layout of a buffered X-channel entry.
// Bit 5 of an address selects the FP bank.
package cv32e40px_rf_wb_pkg;

  localparam int RF_WB_ADDR_W        = 6;
  localparam int RF_WB_DATA_W        = 32;
  localparam int RF_WB_DEFAULT_DEPTH = 4;

  typedef struct packed {
    logic [RF_WB_ADDR_W-1:0] addr;
    logic [RF_WB_DATA_W-1:0] data;
  } rf_wb_entry_t;

endpackage

// File: rtl/cv32e40px_rf_wb_fifo.sv
// Entry FIFO for X-channel register-file writes.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   push, push_entry        write an entry at the tail (caller never pushes when full)
//   pop                     drop the head entry (caller never pops when empty)
//   head                    current head entry
//   full, empty, count      occupancy
//   entry_valid, entry_addr per-slot valid flags and addresses, used to build the scoreboard
// DEPTH must be a power of two so the pointers wrap naturally.
module cv32e40px_rf_wb_fifo
  import cv32e40px_rf_wb_pkg::*;
#(
  parameter  int DEPTH = RF_WB_DEFAULT_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   push,
  input  rf_wb_entry_t                           push_entry,
  input  logic                                   pop,
  output rf_wb_entry_t                           head,
  output logic                                   full,
  output logic                                   empty,
  output logic [PTR_W:0]                         count,
  output logic [DEPTH-1:0]                       entry_valid,
  output logic [DEPTH-1:0][RF_WB_ADDR_W-1:0]     entry_addr
);

  rf_wb_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W:0]    count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    logic [PTR_W-1:0] off;
    off         = '0;
    entry_valid = '0;
    entry_addr  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off            = PTR_W'(i) - rd_ptr_q;
      entry_valid[i] = ({1'b0, off} < count_q);
      entry_addr[i]  = mem_q[i].addr;
    end
  end

endmodule

// File: rtl/cv32e40px_rf_wb_buffer.sv
// Register-file write-back front end.
// Channel A (in-pipeline results) is registered once and drives write port A.
// Channel X (coprocessor results, valid/ready) is buffered in a FIFO whose
// head drives write port B. Because the regfile lets port B win on equal
// addresses, a buffered X write that targets the same register as the live
// port-A write is older and is popped without writing.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   a_valid_i/a_addr_i/a_data_i       channel A request (always accepted)
//   x_valid_i/x_ready_o/x_addr_i/x_data_i  channel X handshake
//   b_stall_i                         port B busy (LSU); holds the FIFO head
//   waddr_a_o/wdata_a_o/we_a_o        regfile write port A
//   waddr_b_o/wdata_b_o/we_b_o        regfile write port B
//   pending_o                         per-register "X write buffered" flags
//   fifo_empty_o                      FIFO empty
// Optional build macro CV32E40PX_RF_WB_BYPASS_EN: when the FIFO is empty an
// X request that cannot collide with channel A is written through port B in
// the same cycle instead of being buffered.
module cv32e40px_rf_wb_buffer
  import cv32e40px_rf_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_WB_ADDR_W,
  parameter int DATA_WIDTH = RF_WB_DATA_W,
  parameter int DEPTH      = RF_WB_DEFAULT_DEPTH,
  parameter int NUM_REGS   = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_valid_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [DATA_WIDTH-1:0] a_data_i,
  input  logic                  x_valid_i,
  output logic                  x_ready_o,
  input  logic [ADDR_WIDTH-1:0] x_addr_i,
  input  logic [DATA_WIDTH-1:0] x_data_i,
  input  logic                  b_stall_i,
  output logic [ADDR_WIDTH-1:0] waddr_a_o,
  output logic [DATA_WIDTH-1:0] wdata_a_o,
  output logic                  we_a_o,
  output logic [ADDR_WIDTH-1:0] waddr_b_o,
  output logic [DATA_WIDTH-1:0] wdata_b_o,
  output logic                  we_b_o,
  output logic [NUM_REGS-1:0]   pending_o,
  output logic                  fifo_empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic                  we_a_q;
  logic [ADDR_WIDTH-1:0] waddr_a_q;
  logic [DATA_WIDTH-1:0] wdata_a_q;

  rf_wb_entry_t                           push_entry;
  rf_wb_entry_t                           head;
  logic                                   push;
  logic                                   pop;
  logic                                   full;
  logic                                   empty;
  logic [PTR_W:0]                         count;
  logic [DEPTH-1:0]                       entry_valid;
  logic [DEPTH-1:0][RF_WB_ADDR_W-1:0]     entry_addr;

  logic drop;
  logic fifo_we_b;
  logic bypass;

  // Stage A: one register stage; writes to x0 are discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_a_q    <= 1'b0;
      waddr_a_q <= '0;
      wdata_a_q <= '0;
    end else begin
      we_a_q <= a_valid_i && (a_addr_i != '0);
      if (a_valid_i) begin
        waddr_a_q <= a_addr_i;
        wdata_a_q <= a_data_i;
      end
    end
  end

  assign waddr_a_o = waddr_a_q;
  assign wdata_a_o = wdata_a_q;
  assign we_a_o    = we_a_q;

  // The head is older than the live port-A write; let port A win.
  assign drop      = !empty && we_a_q && (head.addr == waddr_a_q);
  assign fifo_we_b = !empty && !b_stall_i && !drop;

`ifdef CV32E40PX_RF_WB_BYPASS_EN
  assign bypass = empty && !b_stall_i && x_valid_i && (x_addr_i != '0) &&
                  (x_addr_i != a_addr_i) && (x_addr_i != waddr_a_q);
`else
  assign bypass = 1'b0;
`endif

  // Ready depends only on occupancy: no push into a full FIFO even on a pop.
  assign x_ready_o = !full;
  assign push      = x_valid_i && !full && (x_addr_i != '0) && !bypass;
  assign pop       = fifo_we_b || drop;

  assign push_entry.addr = x_addr_i;
  assign push_entry.data = x_data_i;

  cv32e40px_rf_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (pop),
    .head        (head),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .entry_valid (entry_valid),
    .entry_addr  (entry_addr)
  );

  assign we_b_o       = fifo_we_b || bypass;
  assign waddr_b_o    = bypass ? x_addr_i : head.addr;
  assign wdata_b_o    = bypass ? x_data_i : head.data;
  assign fifo_empty_o = (count == '0);

  // Duplicate addresses simply OR together, so a register stays pending
  // until its last buffered entry leaves.
  always_comb begin
    pending_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) begin
        pending_o[entry_addr[i]] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cv32e40px_rf_wb_buffer.sv
// Scoreboard bench for cv32e40px_rf_wb_buffer. A queue-based reference model
// produces per-cycle expectations and expected port-B writes; a negedge
// monitor pops and compares them against the DUT outputs.
module tb_cv32e40px_rf_wb_buffer;

  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int NR    = 64;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          a_valid_i = 1'b0;
  logic [AW-1:0] a_addr_i  = '0;
  logic [DW-1:0] a_data_i  = '0;
  logic          x_valid_i = 1'b0;
  logic [AW-1:0] x_addr_i  = '0;
  logic [DW-1:0] x_data_i  = '0;
  logic          b_stall_i = 1'b0;
  logic          x_ready_o;
  logic [AW-1:0] waddr_a_o;
  logic [DW-1:0] wdata_a_o;
  logic          we_a_o;
  logic [AW-1:0] waddr_b_o;
  logic [DW-1:0] wdata_b_o;
  logic          we_b_o;
  logic [NR-1:0] pending_o;
  logic          fifo_empty_o;

  cv32e40px_rf_wb_buffer #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .NUM_REGS   (NR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .a_valid_i    (a_valid_i),
    .a_addr_i     (a_addr_i),
    .a_data_i     (a_data_i),
    .x_valid_i    (x_valid_i),
    .x_ready_o    (x_ready_o),
    .x_addr_i     (x_addr_i),
    .x_data_i     (x_data_i),
    .b_stall_i    (b_stall_i),
    .waddr_a_o    (waddr_a_o),
    .wdata_a_o    (wdata_a_o),
    .we_a_o       (we_a_o),
    .waddr_b_o    (waddr_b_o),
    .wdata_b_o    (wdata_b_o),
    .we_b_o       (we_b_o),
    .pending_o    (pending_o),
    .fifo_empty_o (fifo_empty_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  typedef struct {
    logic          we_a;
    logic [AW-1:0] waddr_a;
    logic [DW-1:0] wdata_a;
    logic          we_b;
    logic [NR-1:0] pending;
    logic          empty;
    logic          ready;
  } exp_t;

  ent_t mq[$];
  ent_t exp_b[$];
  exp_t exp_cyc[$];

  logic          m_we_a   = 1'b0;
  logic [AW-1:0] m_addr_a = '0;
  logic [DW-1:0] m_data_a = '0;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: one call per clock cycle with that cycle's inputs.
  task automatic model_step(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                            input logic xv, input logic [AW-1:0] xa, input logic [DW-1:0] xd,
                            input logic st);
    exp_t e;
    ent_t w;
    int   sz;
    logic byp;
    e.we_a    = m_we_a;
    e.waddr_a = m_addr_a;
    e.wdata_a = m_data_a;
    e.pending = '0;
    foreach (mq[i]) e.pending[mq[i].addr] = 1'b1;
    sz      = mq.size();
    e.empty = (sz == 0);
    e.ready = (sz < DEPTH);
    e.we_b  = 1'b0;
    byp     = 1'b0;
    if (sz > 0) begin
      if (m_we_a && mq[0].addr == m_addr_a) begin
        void'(mq.pop_front());
      end else if (!st) begin
        exp_b.push_back(mq[0]);
        e.we_b = 1'b1;
        void'(mq.pop_front());
      end
    end else begin
`ifdef CV32E40PX_RF_WB_BYPASS_EN
      if (!st && xv && xa != '0 && xa != aa && xa != m_addr_a) begin
        byp    = 1'b1;
        w.addr = xa;
        w.data = xd;
        exp_b.push_back(w);
        e.we_b = 1'b1;
      end
`endif
    end
    if (xv && sz < DEPTH && xa != '0 && !byp) begin
      w.addr = xa;
      w.data = xd;
      mq.push_back(w);
    end
    m_we_a = av && (aa != '0);
    if (av) begin
      m_addr_a = aa;
      m_data_a = ad;
    end
    exp_cyc.push_back(e);
  endtask

  task automatic cycle(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic xv, input logic [AW-1:0] xa, input logic [DW-1:0] xd,
                       input logic st);
    @(posedge clk);
    #1;
    a_valid_i = av; a_addr_i = aa; a_data_i = ad;
    x_valid_i = xv; x_addr_i = xa; x_data_i = xd;
    b_stall_i = st;
    model_step(av, aa, ad, xv, xa, xd, st);
  endtask

  task automatic idle(input logic st);
    cycle(1'b0, '0, '0, 1'b0, '0, '0, st);
  endtask

  function automatic logic [AW-1:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 7) return AW'(r);
    if (r == 8) return AW'(40);
    return AW'($urandom_range(0, NR - 1));
  endfunction

  // Monitor: compares on the falling edge, away from the active edge.
  exp_t me;
  ent_t mb;
  always @(negedge clk) begin
    if (exp_cyc.size() > 0) begin
      me = exp_cyc.pop_front();
      chk("we_a", 64'(we_a_o), 64'(me.we_a));
      if (me.we_a) begin
        chk("waddr_a", 64'(waddr_a_o), 64'(me.waddr_a));
        chk("wdata_a", 64'(wdata_a_o), 64'(me.wdata_a));
      end
      chk("we_b", 64'(we_b_o), 64'(me.we_b));
      chk("pending", 64'(pending_o), 64'(me.pending));
      chk("fifo_empty", 64'(fifo_empty_o), 64'(me.empty));
      chk("x_ready", 64'(x_ready_o), 64'(me.ready));
      if (we_b_o) begin
        if (exp_b.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL port_b_unexpected: got write addr %0d data %0h, required none", waddr_b_o, wdata_b_o);
        end else begin
          mb = exp_b.pop_front();
          chk("waddr_b", 64'(waddr_b_o), 64'(mb.addr));
          chk("wdata_b", 64'(wdata_b_o), 64'(mb.data));
        end
      end else if (me.we_b && exp_b.size() > 0) begin
        void'(exp_b.pop_front());
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we_a"},       64'(we_a_o), 64'(0));
    chk({tag, "_we_b"},       64'(we_b_o), 64'(0));
    chk({tag, "_pending"},    64'(pending_o), 64'(0));
    chk({tag, "_fifo_empty"}, 64'(fifo_empty_o), 64'(1));
    chk({tag, "_x_ready"},    64'(x_ready_o), 64'(1));
  endtask

  initial begin
    // Power-on reset state.
    #3;
    check_reset_outputs("por");
    chk("por_waddr_a", 64'(waddr_a_o), 64'(0));
    chk("por_wdata_a", 64'(wdata_a_o), 64'(0));
    chk("por_waddr_b", 64'(waddr_b_o), 64'(0));
    chk("por_wdata_b", 64'(wdata_b_o), 64'(0));
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Single X write to x5.
    cycle(1'b0, '0, '0, 1'b1, 6'd5, 32'hDEADBEEF, 1'b0);
    idle(1'b0);
    idle(1'b0);

    // Fill with port B stalled, hold a fifth request, then drain.
    for (int i = 1; i <= 4; i++) cycle(1'b0, '0, '0, 1'b1, AW'(i), 32'h100 + i, 1'b1);
    cycle(1'b0, '0, '0, 1'b1, 6'd6, 32'h106, 1'b1);
    cycle(1'b0, '0, '0, 1'b1, 6'd6, 32'h106, 1'b1);
    cycle(1'b0, '0, '0, 1'b1, 6'd6, 32'h106, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 6'd6, 32'h106, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b0);

    // Same-address conflict: buffered x7 superseded by port A.
    cycle(1'b1, 6'd7, 32'h22, 1'b1, 6'd7, 32'h11, 1'b0);
    idle(1'b0);
    idle(1'b0);
    // Conflict while stalled still drops the head.
    cycle(1'b1, 6'd9, 32'h33, 1'b1, 6'd9, 32'h44, 1'b1);
    idle(1'b1);
    idle(1'b0);

    // x0 on both channels.
    cycle(1'b1, 6'd0, 32'h55, 1'b1, 6'd0, 32'h66, 1'b0);
    idle(1'b0);

    // FP register from empty FIFO (same-cycle with bypass build).
    cycle(1'b0, '0, '0, 1'b1, 6'd40, 32'h3F800000, 1'b0);
    idle(1'b0);
    idle(1'b0);

    // Reset with three entries buffered.
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, AW'(10 + i), 32'hA0 + i, 1'b1);
    @(posedge clk);
    #1;
    a_valid_i = 1'b0; x_valid_i = 1'b0; b_stall_i = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(posedge clk);
    #2 rst_n = 1'b1;
    mq.delete();
    m_we_a   = 1'b0;
    m_addr_a = '0;
    m_data_a = '0;

    // Randomized traffic.
    for (int n = 0; n < 500; n++) begin
      cycle(($urandom_range(0, 2) == 0), pick_addr(), $urandom(),
            ($urandom_range(0, 1) == 1), pick_addr(), $urandom(),
            ($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b0);

    @(negedge clk);
    #1;
    chk("exp_b_drained", 64'(exp_b.size()), 64'(0));
    chk("model_fifo_drained_vs_dut", 64'(fifo_empty_o), 64'(mq.size() == 0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cv32e40px_rf_wb_buffer.md
Name: cv32e40px_rf_wb_buffer

Overview:
- Producer-side front end of the integer/FP register file write ports.
- Takes in-pipeline results on channel A and decoupled coprocessor/X-interface results on channel X (valid/ready), and drives waddr/wdata/we for regfile write ports A and B.
- Buffers X results in a small FIFO and resolves same-address ordering against the regfile's port-B-wins priority.
- Exports a per-register pending scoreboard for hazard detection.

Parameters:
- ADDR_WIDTH, 6, regfile address width; bit 5 selects FP bank.
- DATA_WIDTH, 32, data width.
- DEPTH, 4, X FIFO entries; power of two, ≥2.
- NUM_REGS, 2**ADDR_WIDTH, scoreboard width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- a_valid_i  in  1  channel A write request; always accepted
- a_addr_i  in  ADDR_WIDTH  channel A destination
- a_data_i  in  DATA_WIDTH  channel A data
- x_valid_i  in  1  channel X request
- x_ready_o  out  1  channel X accept
- x_addr_i  in  ADDR_WIDTH  channel X destination
- x_data_i  in  DATA_WIDTH  channel X data
- b_stall_i  in  1  port B used by LSU this cycle; hold FIFO head
- waddr_a_o  out  ADDR_WIDTH  regfile port A address
- wdata_a_o  out  DATA_WIDTH  regfile port A data
- we_a_o  out  1  regfile port A enable
- waddr_b_o  out  ADDR_WIDTH  regfile port B address
- wdata_b_o  out  DATA_WIDTH  regfile port B data
- we_b_o  out  1  regfile port B enable
- pending_o  out  NUM_REGS  bit r set while an X write to r is buffered
- fifo_empty_o  out  1  FIFO empty

Behaviour:
- Reset: rst_n asynchronous, active-low; clock clk. All flops clear. we_a_o=0, we_b_o=0, addresses/data 0, pending_o=0, fifo_empty_o=1, x_ready_o=1.
- Channel A: registered stage, latency 1. a_valid_i in cycle N gives we_a_o=1 with the captured addr/data in cycle N+1. a_addr_i==0 produces we_a_o=0 (x0 discarded).
- Channel X handshake: transfer when x_valid_i && x_ready_o. x_ready_o = !full; no same-cycle push-when-full, even if a pop occurs. x_addr_i==0 is accepted and discarded: no push, no scoreboard effect.
- Push: accepted entry enters at the tail at the clock edge and is visible at the head no earlier than cycle N+1.
- Port B: combinational from FIFO head. we_b_o = !empty && !b_stall_i && !drop. Pop on we_b_o or drop. b_stall_i holds the head indefinitely.
- Ordering conflict: if a stage-A write is live (we_a_o=1) and the head address equals waddr_a_o in the same cycle, the head is older and superseded. Set drop=1, pop the head without writing (we_b_o=0), and port A writes. This applies even when b_stall_i=1.
- pending_o: OR over valid FIFO entries of one-hot(addr); combinational from state. A register stays pending until its last buffered entry pops. Duplicate addresses are allowed.
- Simultaneous push and pop when not full: count unchanged; pointers wrap modulo DEPTH.
- fifo_empty_o = count==0.
- Reset mid-operation: FIFO contents lost, pending_o clears immediately.

Optional Feature:
- Macro CV32E40PX_RF_WB_BYPASS_EN.
- Defined: when the FIFO is empty, b_stall_i=0, x_valid_i=1 and x_addr_i!=0 and differs from both a_addr_i and waddr_a_o, the X request drives port B combinationally in the same cycle and is not pushed. x_ready_o=1.
- Undefined: every accepted X entry goes through the FIFO; minimum latency 1 cycle.

Decomposition:
- Package cv32e40px_rf_wb_pkg holds:
  - typedef struct packed rf_wb_entry_t {addr, data}, sized from package constants RF_WB_ADDR_W=6 and RF_WB_DATA_W=32;
  - localparam RF_WB_DEFAULT_DEPTH=4.
- Sub-module cv32e40px_rf_wb_fifo: the entry FIFO with push/pop/full/empty/count and exposed entry-valid vector plus addresses for scoreboard generation.
- Top module holds the A stage, drop logic, bypass and scoreboard OR-tree.

Test Plan:
- Reset mid-stream: 3 X entries buffered, pulse rst_n low → pending_o=0, fifo_empty_o=1, we_b_o=0 asynchronously.
- X write: x addr=5, data=0xDEADBEEF, b_stall_i=0, no bypass. Cycle N+1 shows we_b_o=1, waddr_b_o=5, wdata_b_o=0xDEADBEEF, pending_o[5]=1 during N+1, then 0 after the pop.
- Full: push 4 entries with b_stall_i=1 → x_ready_o=0 and the 5th request is held. Deassert stall → drains in order, one per cycle, 4 cycles; x_ready_o=1 after the first pop.
- Conflict: head addr=7 (data 0x11) and A writes addr 7 (0x22) that cycle → we_a_o=1 with 0x22, we_b_o=0, head popped, regfile x7=0x22.
- x0 discard: a_addr_i=0 and x_addr_i=0 → we_a_o=0, no push, pending_o unchanged, x_ready_o=1.
- Bypass (macro defined): empty FIFO, x addr=40 (FP f8), data 0x3F800000 → we_b_o=1 in the same cycle, fifo_empty_o stays 1. Without the macro → we_b_o=1 one cycle later.
